// File: rtl/id_inst_queue_ctrl.sv
// Decode-entry instruction queue for the ID stage.
// Two-slot FIFO with an occupancy FSM, load-use hazard detection,
// redirect flush and a saturating hazard-stall counter.
module id_inst_queue_ctrl #(
   parameter int INST_W = 32,
   parameter int PC_W   = 32,
   parameter int HCNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [INST_W-1:0] if_inst,
   input  logic [PC_W-1:0]   if_pc,
   output logic              if_ready,
   input  logic              flush,
   input  logic              ex_ld_valid,
   input  logic [4:0]        ex_ld_rd,
   input  logic              ex_ready,
   output logic              id_valid,
   output logic [INST_W-1:0] id_inst,
   output logic [PC_W-1:0]   id_pc,
   output logic              id_stall,
   output logic [HCNT_W-1:0] hz_count
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;
   localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

   logic [1:0]        state_q, state_d;
   logic              head_q, head_d;
   logic [HCNT_W-1:0] hz_cnt_q, hz_cnt_d;
   logic [INST_W-1:0] slot_inst_q [2];
   logic [PC_W-1:0]   slot_pc_q   [2];

   logic              push, pop, hz, tail;
   logic              uses_rs1, uses_rs2;
   logic [INST_W-1:0] head_inst;
   logic [PC_W-1:0]   head_pc;
   logic [6:0]        opcode;
   logic [4:0]        rs1, rs2;

   // Head selection, tail position and handshakes
   assign head_inst = slot_inst_q[head_q];
   assign head_pc   = slot_pc_q[head_q];
   assign opcode    = head_inst[6:0];
   assign rs1       = head_inst[19:15];
   assign rs2       = head_inst[24:20];
   assign tail      = head_q ^ (state_q == S_ONE);
   assign push      = if_valid & if_ready;
   assign pop       = id_valid & ex_ready;

   // Decode which source registers the head instruction reads
   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (opcode)
         7'b0110011, 7'b0100011, 7'b1100011: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
         default: ;
      endcase
   end

   // Load-use hazard: head reads the register the load in EX is writing
   always_comb begin
      hz = ex_ld_valid & (ex_ld_rd != 5'd0) & (state_q != S_EMPTY) &
           ((uses_rs1 & (rs1 == ex_ld_rd)) | (uses_rs2 & (rs2 == ex_ld_rd)));
   end

   // Occupancy state, head pointer and stall counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_EMPTY;
         head_q   <= 1'b0;
         hz_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         hz_cnt_q <= hz_cnt_d;
      end
   end

   // Next occupancy state; flush overrides any push or pop
   always_comb begin
      state_d = state_q;
      head_d  = head_q ^ pop;
      if (flush) begin
         state_d = S_EMPTY;
         head_d  = 1'b0;
      end else begin
         case (state_q)
            S_EMPTY: if (push) state_d = S_ONE;
            S_ONE: begin
               if (push && !pop)      state_d = S_FULL;
               else if (pop && !push) state_d = S_EMPTY;
            end
            S_FULL:  if (pop) state_d = S_ONE;
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // Saturating count of hazard cycles, independent of flush
   always_comb begin
      hz_cnt_d = hz_cnt_q;
      if (hz && (hz_cnt_q != {HCNT_W{1'b1}})) hz_cnt_d = hz_cnt_q + HCNT_W'(1);
   end

   // Slot payload writes at the tail; data is not reset
   always_ff @(posedge clk) begin
      if (push) begin
         slot_inst_q[tail] <= if_inst;
         slot_pc_q[tail]   <= if_pc;
      end
   end

   // Outputs: masked to a NOP / zero PC when the queue is empty
   always_comb begin
      if_ready = (state_q != S_FULL) & ~flush;
      id_valid = (state_q != S_EMPTY) & ~hz & ~flush;
      id_stall = hz;
      id_inst  = NOP_INST;
      id_pc    = '0;
      if (state_q != S_EMPTY) begin
         id_inst = head_inst;
         id_pc   = head_pc;
      end
      hz_count = hz_cnt_q;
   end

endmodule

// File: tb/tb_id_inst_queue_ctrl.sv
// Testbench for id_inst_queue_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_id_inst_queue_ctrl;

   localparam int INST_W = 32;
   localparam int PC_W   = 32;
   localparam int HCNT_W = 4;
   localparam int HMAX   = (1 << HCNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst, if_valid, if_ready, flush, ex_ld_valid, ex_ready;
   logic              id_valid, id_stall;
   logic [INST_W-1:0] if_inst, id_inst;
   logic [PC_W-1:0]   if_pc, id_pc;
   logic [4:0]        ex_ld_rd;
   logic [HCNT_W-1:0] hz_count;

   int checks = 0;
   int fails  = 0;

   // reference model state
   logic [INST_W-1:0] mq_inst[$];
   logic [PC_W-1:0]   mq_pc[$];
   int                m_hz;
   logic              e_ready, e_valid, e_stall;
   logic [INST_W-1:0] e_inst;
   logic [PC_W-1:0]   e_pc;

   id_inst_queue_ctrl #(.INST_W(INST_W), .PC_W(PC_W), .HCNT_W(HCNT_W)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
      .if_ready(if_ready), .flush(flush), .ex_ld_valid(ex_ld_valid), .ex_ld_rd(ex_ld_rd),
      .ex_ready(ex_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
      .id_stall(id_stall), .hz_count(hz_count)
   );

   always #5 clk = ~clk;

   function automatic bit reads_rs1(logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
   endfunction

   function automatic bit reads_rs2(logic [6:0] op);
      return op inside {7'b0110011, 7'b0100011, 7'b1100011};
   endfunction

   // Expected combinational outputs from the model queue and current inputs
   task automatic model_eval();
      logic [INST_W-1:0] h;
      bit hit;
      e_ready = (mq_inst.size() < 2) && !flush;
      e_inst  = 32'h0000_0013;
      e_pc    = '0;
      e_stall = 1'b0;
      if (mq_inst.size() > 0) begin
         h      = mq_inst[0];
         e_inst = h;
         e_pc   = mq_pc[0];
         hit    = (reads_rs1(h[6:0]) && h[19:15] == ex_ld_rd) ||
                  (reads_rs2(h[6:0]) && h[24:20] == ex_ld_rd);
         e_stall = ex_ld_valid && ex_ld_rd != 0 && hit;
      end
      e_valid = (mq_inst.size() > 0) && !e_stall && !flush;
   endtask

   task automatic model_reset();
      mq_inst.delete();
      mq_pc.delete();
      m_hz = 0;
   endtask

   // Advance one clock, updating the model with the transfers of this cycle
   task automatic tick();
      bit do_pop, do_push;
      model_eval();
      do_pop  = e_valid && ex_ready;
      do_push = if_valid && e_ready;
      @(posedge clk);
      if (e_stall && m_hz < HMAX) m_hz++;
      if (flush) begin
         mq_inst.delete();
         mq_pc.delete();
      end else begin
         if (do_pop) begin
            void'(mq_inst.pop_front());
            void'(mq_pc.pop_front());
         end
         if (do_push) begin
            mq_inst.push_back(if_inst);
            mq_pc.push_back(if_pc);
         end
      end
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_valid = 0; if_inst = '0; if_pc = '0; flush = 0;
      ex_ld_valid = 0; ex_ld_rd = '0; ex_ready = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (if_ready !== 1'b1) begin fails++; $display("FAIL reset_if_ready: got %b exp 1", if_ready); end
      checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid: got %b exp 0", id_valid); end
      checks++; if (id_stall !== 1'b0) begin fails++; $display("FAIL reset_id_stall: got %b exp 0", id_stall); end
      checks++; if (id_inst !== 32'h13) begin fails++; $display("FAIL reset_id_inst: got %h exp 00000013", id_inst); end
      checks++; if (id_pc !== 32'h0) begin fails++; $display("FAIL reset_id_pc: got %h exp 0", id_pc); end
      checks++; if (hz_count !== 4'd0) begin fails++; $display("FAIL reset_hz_count: got %0d exp 0", hz_count); end
   endtask

   task automatic test_single();
      apply_reset();
      if_valid = 1; if_inst = 32'h003100b3; if_pc = 32'h100; ex_ready = 1;
      #1;
      checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL single_no_bypass: got %b exp 0", id_valid); end
      tick();
      if_valid = 0;
      #1;
      checks++; if (id_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b exp 1", id_valid); end
      checks++; if (id_inst !== 32'h003100b3) begin fails++; $display("FAIL single_inst: got %h exp 003100b3", id_inst); end
      checks++; if (id_pc !== 32'h100) begin fails++; $display("FAIL single_pc: got %h exp 00000100", id_pc); end
      tick();
      checks++; if (id_valid !== 1'b0 || id_inst !== 32'h13) begin fails++; $display("FAIL single_empty: got valid=%b inst=%h exp 0/00000013", id_valid, id_inst); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      ex_ready = 0;
      if_valid = 1; if_inst = 32'h00a00093; if_pc = 32'h200; tick();
      if_inst = 32'h01400113; if_pc = 32'h204; tick();
      if_inst = 32'h01e00193; if_pc = 32'h208;
      #1;
      checks++; if (if_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready: got %b exp 0", if_ready); end
      tick();
      ex_ready = 1;
      #1;
      checks++; if (if_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready_exr: got %b exp 0", if_ready); end
      checks++; if (id_valid !== 1'b1 || id_inst !== 32'h00a00093) begin fails++; $display("FAIL b2b_head_a: got valid=%b inst=%h exp 1/00a00093", id_valid, id_inst); end
      tick();
      checks++; if (if_ready !== 1'b1) begin fails++; $display("FAIL b2b_one_ready: got %b exp 1", if_ready); end
      checks++; if (id_inst !== 32'h01400113 || id_pc !== 32'h204) begin fails++; $display("FAIL b2b_head_b: got %h/%h exp 01400113/00000204", id_inst, id_pc); end
      tick();
      if_valid = 0;
      #1;
      checks++; if (id_valid !== 1'b1 || id_inst !== 32'h01e00193 || id_pc !== 32'h208) begin fails++; $display("FAIL b2b_head_c: got %b %h/%h exp 1 01e00193/00000208", id_valid, id_inst, id_pc); end
      tick();
      checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b exp 0", id_valid); end
   endtask

   task automatic test_hazard();
      apply_reset();
      if_valid = 1; if_inst = 32'h006281b3; if_pc = 32'h300; tick();
      if_valid = 0; ex_ld_valid = 1; ex_ld_rd = 5'd6; ex_ready = 1;
      #1;
      checks++; if (id_valid !== 1'b0 || id_stall !== 1'b1) begin fails++; $display("FAIL hz_stall: got valid=%b stall=%b exp 0/1", id_valid, id_stall); end
      tick();
      checks++; if (hz_count !== 4'd1) begin fails++; $display("FAIL hz_count_one: got %0d exp 1", hz_count); end
      ex_ld_valid = 0;
      #1;
      checks++; if (id_valid !== 1'b1 || id_stall !== 1'b0) begin fails++; $display("FAIL hz_release: got valid=%b stall=%b exp 1/0", id_valid, id_stall); end
      tick();
      checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL hz_issued: got %b exp 0", id_valid); end
   endtask

   task automatic test_no_stall();
      apply_reset();
      // lui x5 whose immediate bits alias rs1=6
      if_valid = 1; if_inst = 32'h000302b7; if_pc = 32'h400; tick();
      if_valid = 0; ex_ld_valid = 1; ex_ld_rd = 5'd6; ex_ready = 0;
      #1;
      checks++; if (id_stall !== 1'b0 || id_valid !== 1'b1) begin fails++; $display("FAIL lui_no_stall: got stall=%b valid=%b exp 0/1", id_stall, id_valid); end
      ex_ready = 1; tick();
      // addi x1,x0,5 against a load to x0
      ex_ld_valid = 0; ex_ready = 0;
      if_valid = 1; if_inst = 32'h00500093; if_pc = 32'h404; tick();
      if_valid = 0; ex_ld_valid = 1; ex_ld_rd = 5'd0;
      #1;
      checks++; if (id_stall !== 1'b0 || id_valid !== 1'b1) begin fails++; $display("FAIL x0_no_stall: got stall=%b valid=%b exp 0/1", id_stall, id_valid); end
      ex_ready = 1; tick();
      // sw x6,0(x2) hazards through rs2
      ex_ld_valid = 0; ex_ready = 0;
      if_valid = 1; if_inst = 32'h00612023; if_pc = 32'h408; tick();
      if_valid = 0; ex_ld_valid = 1; ex_ld_rd = 5'd6;
      #1;
      checks++; if (id_stall !== 1'b1 || id_valid !== 1'b0) begin fails++; $display("FAIL sw_rs2_stall: got stall=%b valid=%b exp 1/0", id_stall, id_valid); end
   endtask

   task automatic test_flush();
      apply_reset();
      ex_ready = 0;
      if_valid = 1; if_inst = 32'h00a00093; if_pc = 32'h500; tick();
      if_inst = 32'h01400113; if_pc = 32'h504; tick();
      if_inst = 32'h01e00193; if_pc = 32'h508; flush = 1; ex_ready = 1;
      #1;
      checks++; if (id_valid !== 1'b0 || if_ready !== 1'b0) begin fails++; $display("FAIL flush_cycle: got valid=%b ready=%b exp 0/0", id_valid, if_ready); end
      tick();
      flush = 0; if_valid = 0;
      #1;
      checks++; if (id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'h0 || if_ready !== 1'b1) begin fails++; $display("FAIL flush_empty: got %b %h %h %b exp 0 00000013 00000000 1", id_valid, id_inst, id_pc, if_ready); end
   endtask

   task automatic test_saturate();
      apply_reset();
      if_valid = 1; if_inst = 32'h006281b3; if_pc = 32'h600; tick();
      if_inst = 32'h00a00093; if_pc = 32'h604;
      ex_ld_valid = 1; ex_ld_rd = 5'd5; ex_ready = 1;
      tick();
      if_valid = 0;
      for (int i = 0; i < (1 << HCNT_W) + 2; i++) tick();
      checks++; if (hz_count !== 4'hf) begin fails++; $display("FAIL hz_saturate: got %0d exp 15", hz_count); end
      #2;
      rst = 1;
      model_reset();
      #1;
      checks++; if (if_ready !== 1'b1 || id_valid !== 1'b0 || id_stall !== 1'b0) begin fails++; $display("FAIL async_rst_ctrl: got ready=%b valid=%b stall=%b exp 1/0/0", if_ready, id_valid, id_stall); end
      checks++; if (id_inst !== 32'h13 || id_pc !== 32'h0 || hz_count !== 4'd0) begin fails++; $display("FAIL async_rst_data: got %h %h %0d exp 00000013 00000000 0", id_inst, id_pc, hz_count); end
      @(negedge clk);
      rst = 0;
      idle_inputs();
      #1;
   endtask

   task automatic test_random();
      logic [6:0] ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b1100111, 7'b0110111, 7'b1101111};
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         if_valid    = ($urandom_range(0, 3) != 0);
         if_inst     = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        3'($urandom), 5'($urandom), ops[$urandom_range(0, 7)]};
         if_pc       = $urandom;
         flush       = ($urandom_range(0, 11) == 0);
         ex_ld_valid = ($urandom_range(0, 2) == 0);
         ex_ld_rd    = 5'($urandom_range(0, 7));
         ex_ready    = ($urandom_range(0, 2) != 0);
         #1;
         model_eval();
         checks++; if (if_ready !== e_ready) begin fails++; $display("FAIL rnd_if_ready[%0d]: got %b exp %b", n, if_ready, e_ready); end
         checks++; if (id_valid !== e_valid) begin fails++; $display("FAIL rnd_id_valid[%0d]: got %b exp %b", n, id_valid, e_valid); end
         checks++; if (id_stall !== e_stall) begin fails++; $display("FAIL rnd_id_stall[%0d]: got %b exp %b", n, id_stall, e_stall); end
         checks++; if (id_inst !== e_inst) begin fails++; $display("FAIL rnd_id_inst[%0d]: got %h exp %h", n, id_inst, e_inst); end
         checks++; if (id_pc !== e_pc) begin fails++; $display("FAIL rnd_id_pc[%0d]: got %h exp %h", n, id_pc, e_pc); end
         checks++; if (hz_count !== HCNT_W'(m_hz)) begin fails++; $display("FAIL rnd_hz_count[%0d]: got %0d exp %0d", n, hz_count, m_hz); end
         tick();
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      model_reset();
      test_reset();
      test_single();
      test_back_to_back();
      test_hazard();
      test_no_stall();
      test_flush();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
